spi_cmd_decoder: RTL and testbench

Clock-domain consumer for the SPI byte slave: detects completed bytes from the slave's `busy` toggle pair, parses command frames, drives the cartridge memory bus, and supplies the next `out_byte` for the slave to shift out on MISO. Sits directly downstream of the SPI byte slave, between it and the SNES cart memory arbiter, so a host MCU can read and write cart memory over SPI.

---
 rtl/spi_cmd_decoder.sv | 140 ++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: parses SPI command frames into cart memory bus cycles and MISO bytes.
// Define SPI_CMD_ID_EN to decode the 8'h9F device ID command.
module spi_cmd_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_cs_n,
  input  logic        spi_busy,
  input  logic [7:0]  spi_in_byte,
  output logic [7:0]  spi_out_byte,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        cmd_err
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, ID, IGNORE} state_t;
`ifdef SPI_CMD_ID_EN
  localparam logic [23:0] ID_VALUE = 24'hC05E01;
  logic [1:0] idx, idx_n;
`endif
  state_t state, nxt;
  logic [1:0] busy_s, cs_s, cnt, cnt_n;
  logic busy_q, cs_q, re_q, rd, rd_n;
  logic [23:0] addr_n;
  logic [7:0] wdata_n, out_n;
  logic we_n, re_n, err_n;
  logic cs, cs_fall, done, op_ok, op_id;
  assign cs = cs_s[1];
  assign cs_fall = cs_q & ~cs;
  assign done = busy_q & ~busy_s[1];
  assign op_ok = spi_in_byte == 8'h02 || spi_in_byte == 8'h03;
`ifdef SPI_CMD_ID_EN
  assign op_id = spi_in_byte == 8'h9F;
`else
  assign op_id = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy_s <= 2'b00;
      busy_q <= 1'b0;
      cs_s <= 2'b11;
      cs_q <= 1'b1;
      cnt <= 2'd0;
      rd <= 1'b0;
      re_q <= 1'b0;
      spi_out_byte <= 8'hFF;
      mem_addr <= 24'd0;
      mem_wdata <= 8'd0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      cmd_err <= 1'b0;
`ifdef SPI_CMD_ID_EN
      idx <= 2'd0;
`endif
    end else begin
      state <= nxt;
      busy_s <= {busy_s[0], spi_busy};
      busy_q <= busy_s[1];
      cs_s <= {cs_s[0], spi_cs_n};
      cs_q <= cs;
      cnt <= cnt_n;
      rd <= rd_n;
      re_q <= mem_re;
      spi_out_byte <= out_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      mem_we <= we_n;
      mem_re <= re_n;
      cmd_err <= err_n;
`ifdef SPI_CMD_ID_EN
      idx <= idx_n;
`endif
    end
  end
  always_comb begin
    nxt = state;
    if (cs) nxt = IDLE;
    else case (state)
      IDLE: nxt = cs_fall ? CMD : IDLE;
      CMD: if (done) nxt = op_ok ? ADDR : op_id ? ID : IGNORE;
      ADDR: if (done && cnt == 2'd2) nxt = rd ? READ : WRITE;
      default: nxt = state;
    endcase
  end
  // chip select high overrides any byte-done seen in the same cycle
  always_comb begin
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    out_n = spi_out_byte;
    we_n = 1'b0;
    re_n = 1'b0;
    err_n = 1'b0;
    cnt_n = cnt;
    rd_n = rd;
`ifdef SPI_CMD_ID_EN
    idx_n = idx;
`endif
    if (cs) out_n = 8'hFF;
    else case (state)
      CMD: if (done) begin
        rd_n = spi_in_byte[0];
        cnt_n = 2'd0;
        err_n = !op_ok && !op_id;
        out_n = 8'hFF;
`ifdef SPI_CMD_ID_EN
        if (op_id) out_n = ID_VALUE[23:16];
        idx_n = 2'd1;
`endif
      end
      ADDR: if (done) begin
        addr_n = {mem_addr[15:0], spi_in_byte};
        cnt_n = cnt + 2'd1;
        re_n = cnt == 2'd2 && rd;
      end
      WRITE: begin
        if (mem_we) addr_n = mem_addr + 24'd1;
        if (done) begin
          wdata_n = spi_in_byte;
          we_n = 1'b1;
        end
      end
      READ: begin
        if (re_q) out_n = mem_rdata;
        if (done) begin
          addr_n = mem_addr + 24'd1;
          re_n = 1'b1;
        end
      end
`ifdef SPI_CMD_ID_EN
      ID: if (done) begin
        out_n = idx == 2'd1 ? ID_VALUE[15:8] : idx == 2'd2 ? ID_VALUE[7:0] : 8'hFF;
        idx_n = idx == 2'd3 ? 2'd3 : idx + 2'd1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: directed frame-level checks of spi_cmd_decoder.
module tb_spi_cmd_decoder;
  logic clk = 1'b0, rst_n = 1'b0, spi_cs_n = 1'b1, spi_busy = 1'b0;
  logic [7:0] spi_in_byte = 8'h00, mem_rdata = 8'h00;
  logic [7:0] spi_out_byte, mem_wdata;
  logic [23:0] mem_addr;
  logic mem_we, mem_re, cmd_err;
  int checks = 0, errors = 0;
  int we_cnt = 0, re_cnt = 0, err_cnt = 0, viol = 0;
  logic [23:0] we_addr [8];
  logic [7:0] we_data [8];
  logic [23:0] re_addr [8];
  logic prev_we = 1'b0, prev_re = 1'b0;

  spi_cmd_decoder dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_busy(spi_busy),
    .spi_in_byte(spi_in_byte), .spi_out_byte(spi_out_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_re) mem_rdata <= mem_addr == 24'h001000 ? 8'h5A : mem_addr == 24'h001001 ? 8'hA5 : 8'h3C;

  always @(negedge clk) begin
    if (mem_we) begin
      we_addr[we_cnt & 7] = mem_addr;
      we_data[we_cnt & 7] = mem_wdata;
      we_cnt++;
    end
    if (mem_re) begin
      re_addr[re_cnt & 7] = mem_addr;
      re_cnt++;
    end
    if (cmd_err) err_cnt++;
    if ((mem_we && mem_re) || (mem_we && prev_we) || (mem_re && prev_re)) viol++;
    prev_we = mem_we;
    prev_re = mem_re;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    cyc(4);
  endtask

  task automatic cs_high();
    spi_cs_n = 1'b1;
    cyc(6);
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_in_byte = b;
    spi_busy = 1'b1;
    cyc(4);
    spi_busy = 1'b0;
    cyc(8);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    cyc(3);
    checks++; if (spi_out_byte !== 8'hFF) begin errors++; $display("FAIL reset_out: got %h expected ff", spi_out_byte); end
    checks++; if (mem_addr !== 24'd0) begin errors++; $display("FAIL reset_addr: got %h expected 000000", mem_addr); end
    checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 00", mem_wdata); end
    checks++; if ({mem_we, mem_re, cmd_err} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {mem_we, mem_re, cmd_err}); end
    rst_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_write();
    int b = we_cnt, r = re_cnt;
    cs_low();
    send_byte(8'h02); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    send_byte(8'hAB); send_byte(8'hCD);
    cs_high();
    checks++; if (we_cnt - b !== 2) begin errors++; $display("FAIL write_count: got %0d expected 2", we_cnt - b); end
    checks++; if (we_addr[b & 7] !== 24'h123456 || we_data[b & 7] !== 8'hAB) begin errors++; $display("FAIL write0: got %h/%h expected 123456/ab", we_addr[b & 7], we_data[b & 7]); end
    checks++; if (we_addr[(b + 1) & 7] !== 24'h123457 || we_data[(b + 1) & 7] !== 8'hCD) begin errors++; $display("FAIL write1: got %h/%h expected 123457/cd", we_addr[(b + 1) & 7], we_data[(b + 1) & 7]); end
    checks++; if (re_cnt - r !== 0) begin errors++; $display("FAIL write_no_re: got %0d expected 0", re_cnt - r); end
  endtask

  task automatic test_read();
    int r = re_cnt, w = we_cnt;
    cs_low();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10);
    checks++; if (spi_out_byte !== 8'hFF) begin errors++; $display("FAIL read_addr_out: got %h expected ff", spi_out_byte); end
    send_byte(8'h00);
    checks++; if (spi_out_byte !== 8'h5A) begin errors++; $display("FAIL read_data0: got %h expected 5a", spi_out_byte); end
    send_byte(8'h55);
    checks++; if (spi_out_byte !== 8'hA5) begin errors++; $display("FAIL read_data1: got %h expected a5", spi_out_byte); end
    send_byte(8'h55);
    checks++; if (spi_out_byte !== 8'h3C) begin errors++; $display("FAIL read_data2: got %h expected 3c", spi_out_byte); end
    cs_high();
    checks++; if (spi_out_byte !== 8'hFF) begin errors++; $display("FAIL read_cs_out: got %h expected ff", spi_out_byte); end
    checks++; if (re_cnt - r !== 3) begin errors++; $display("FAIL read_count: got %0d expected 3", re_cnt - r); end
    checks++; if (re_addr[r & 7] !== 24'h001000 || re_addr[(r + 1) & 7] !== 24'h001001) begin errors++; $display("FAIL read_addrs: got %h,%h expected 001000,001001", re_addr[r & 7], re_addr[(r + 1) & 7]); end
    checks++; if (we_cnt - w !== 0) begin errors++; $display("FAIL read_no_we: got %0d expected 0", we_cnt - w); end
  endtask

  task automatic test_wrap();
    int b = we_cnt;
    cs_low();
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h22);
    cs_high();
    checks++; if (we_cnt - b !== 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", we_cnt - b); end
    checks++; if (we_addr[b & 7] !== 24'hFFFFFF || we_data[b & 7] !== 8'h11) begin errors++; $display("FAIL wrap0: got %h/%h expected ffffff/11", we_addr[b & 7], we_data[b & 7]); end
    checks++; if (we_addr[(b + 1) & 7] !== 24'h000000 || we_data[(b + 1) & 7] !== 8'h22) begin errors++; $display("FAIL wrap1: got %h/%h expected 000000/22", we_addr[(b + 1) & 7], we_data[(b + 1) & 7]); end
  endtask

  task automatic test_unknown();
    int e = err_cnt, w = we_cnt, r = re_cnt;
    cs_low();
    send_byte(8'h7E);
    send_byte(8'h00);
    checks++; if (spi_out_byte !== 8'hFF) begin errors++; $display("FAIL unk_out: got %h expected ff", spi_out_byte); end
    cs_high();
    checks++; if (err_cnt - e !== 1) begin errors++; $display("FAIL unk_err: got %0d expected 1", err_cnt - e); end
    checks++; if (we_cnt - w + re_cnt - r !== 0) begin errors++; $display("FAIL unk_strobes: got %0d expected 0", we_cnt - w + re_cnt - r); end
  endtask

  task automatic test_id();
    int e = err_cnt;
    cs_low();
    send_byte(8'h9F);
`ifdef SPI_CMD_ID_EN
    checks++; if (spi_out_byte !== 8'hC0) begin errors++; $display("FAIL id0: got %h expected c0", spi_out_byte); end
    send_byte(8'h00);
    checks++; if (spi_out_byte !== 8'h5E) begin errors++; $display("FAIL id1: got %h expected 5e", spi_out_byte); end
    send_byte(8'h00);
    checks++; if (spi_out_byte !== 8'h01) begin errors++; $display("FAIL id2: got %h expected 01", spi_out_byte); end
    send_byte(8'h00);
    checks++; if (spi_out_byte !== 8'hFF) begin errors++; $display("FAIL id3: got %h expected ff", spi_out_byte); end
    send_byte(8'h00);
    checks++; if (spi_out_byte !== 8'hFF) begin errors++; $display("FAIL id4: got %h expected ff", spi_out_byte); end
    cs_high();
    checks++; if (err_cnt - e !== 0) begin errors++; $display("FAIL id_err: got %0d expected 0", err_cnt - e); end
`else
    send_byte(8'h00);
    checks++; if (spi_out_byte !== 8'hFF) begin errors++; $display("FAIL id_off_out: got %h expected ff", spi_out_byte); end
    cs_high();
    checks++; if (err_cnt - e !== 1) begin errors++; $display("FAIL id_off_err: got %0d expected 1", err_cnt - e); end
`endif
  endtask

  task automatic test_abort();
    int b = we_cnt;
    cs_low();
    send_byte(8'h02); send_byte(8'h12);
    cs_high();
    checks++; if (we_cnt - b !== 0) begin errors++; $display("FAIL abort_no_we: got %0d expected 0", we_cnt - b); end
    cs_low();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h77);
    cs_high();
    checks++; if (we_cnt - b !== 1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", we_cnt - b); end
    checks++; if (we_addr[b & 7] !== 24'h000001 || we_data[b & 7] !== 8'h77) begin errors++; $display("FAIL abort_next: got %h/%h expected 000001/77", we_addr[b & 7], we_data[b & 7]); end
  endtask

  task automatic test_coincident();
    int b = we_cnt;
    cs_low();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    spi_in_byte = 8'h99;
    spi_busy = 1'b1;
    cyc(4);
    spi_busy = 1'b0;
    spi_cs_n = 1'b1;
    cyc(10);
    checks++; if (we_cnt - b !== 0) begin errors++; $display("FAIL coincident_no_we: got %0d expected 0", we_cnt - b); end
  endtask

  task automatic test_reset_mid_read();
    cs_low();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    checks++; if (spi_out_byte !== 8'h5A || mem_addr !== 24'h001000) begin errors++; $display("FAIL midread_pre: got %h/%h expected 5a/001000", spi_out_byte, mem_addr); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (spi_out_byte !== 8'hFF || mem_addr !== 24'd0 || mem_wdata !== 8'd0) begin errors++; $display("FAIL midread_rst: got %h/%h/%h expected ff/000000/00", spi_out_byte, mem_addr, mem_wdata); end
    checks++; if ({mem_we, mem_re, cmd_err} !== 3'b000) begin errors++; $display("FAIL midread_strobes: got %b expected 000", {mem_we, mem_re, cmd_err}); end
    spi_cs_n = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    checks++; if (viol !== 0) begin errors++; $display("FAIL strobe_rules: got %0d expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_unknown();
    test_id();
    test_abort();
    test_coincident();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
